// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch stage.
//   - address/data widths of the instruction port
//   - FSM state encoding (FETCH, HOLD)
//   - reset PC default, bubble encoding (NOP) and PC increment
package fetch_pkg;

   localparam int InstAddrWidth = 32;
   localparam int InstDataWidth = 32;

   localparam logic [InstAddrWidth-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [InstDataWidth-1:0] NOP              = 32'h0000_0000;
   localparam logic [InstAddrWidth-1:0] PC_INC           = 32'd4;

   typedef enum logic {
      FETCH = 1'b0,
      HOLD  = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: one-entry {pc_plus4, inst} holding register that
// keeps a completed fetch while the hazard unit stalls IF/ID.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset (clears entry)
//   load_i         - capture pc_plus4_i / inst_i
//   unload_i       - entry consumed; cleared back to empty contents
//   pc_plus4_i/o   - address of the buffered instruction + 4
//   inst_i/o       - buffered instruction word
module fetch_skid_buffer
   import fetch_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load_i,
   input  logic                     unload_i,
   input  logic [InstAddrWidth-1:0] pc_plus4_i,
   input  logic [InstDataWidth-1:0] inst_i,
   output logic [InstAddrWidth-1:0] pc_plus4_o,
   output logic [InstDataWidth-1:0] inst_o
);

   logic [InstAddrWidth-1:0] pc_plus4_q;
   logic [InstDataWidth-1:0] inst_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_plus4_q <= '0;
         inst_q     <= NOP;
      end else if (load_i) begin
         pc_plus4_q <= pc_plus4_i;
         inst_q     <= inst_i;
      end else if (unload_i) begin
         pc_plus4_q <= '0;
         inst_q     <= NOP;
      end
   end

   assign pc_plus4_o = pc_plus4_q;
   assign inst_o     = inst_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction-fetch stage. Owns the PC, drives the
// instruction-memory request handshake and loads the IF/ID register.
// Optional feature macro: FETCH_DELAY_SLOT_EN
//   defined   - word in flight when a redirect is accepted goes to ID
//   undefined - that word is squashed and replaced by a bubble
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   stall_IF            - hazard unit holds PC and IF/ID
//   is_branch           - redirect request from ID
//   branch_address      - redirect target (low two bits ignored)
//   imem_req/imem_addr  - fetch request and address (address == PC)
//   imem_ready          - response valid (may come with the request)
//   imem_rdata          - instruction word
//   pc_plus4_ID/inst_ID/valid_ID - IF/ID register
//   fetch_stall         - request outstanding without response
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [InstAddrWidth-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     stall_IF,
   input  logic                     is_branch,
   input  logic [InstAddrWidth-1:0] branch_address,
   output logic                     imem_req,
   output logic [InstAddrWidth-1:0] imem_addr,
   input  logic                     imem_ready,
   input  logic [InstDataWidth-1:0] imem_rdata,
   output logic [InstAddrWidth-1:0] pc_plus4_ID,
   output logic [InstDataWidth-1:0] inst_ID,
   output logic                     valid_ID,
   output logic                     fetch_stall
);

`ifdef FETCH_DELAY_SLOT_EN
   localparam bit DelaySlot = 1'b1;
`else
   localparam bit DelaySlot = 1'b0;
`endif

   fetch_state_e             state_q, state_d;
   logic [InstAddrWidth-1:0] pc_q, pc_d;
   logic [InstAddrWidth-1:0] redir_pc_q, redir_pc_d;
   logic                     redir_pend_q, redir_pend_d;
   logic [InstAddrWidth-1:0] pc_plus4_id_q, pc_plus4_id_d;
   logic [InstDataWidth-1:0] inst_id_q, inst_id_d;
   logic                     valid_id_q, valid_id_d;

   logic                     skid_load, skid_unload;
   logic [InstAddrWidth-1:0] skid_pc_plus4;
   logic [InstDataWidth-1:0] skid_inst;

   logic                     fire, accept, redir_go;
   logic [InstAddrWidth-1:0] pc_plus4, br_tgt, redir_tgt;

   // Request is dropped combinationally while reset is held so an
   // outstanding fetch is abandoned immediately.
   assign imem_req    = (state_q == FETCH) && !rst;
   assign imem_addr   = pc_q;
   assign fetch_stall = imem_req && !imem_ready;

   assign fire     = imem_req && imem_ready;
   assign pc_plus4 = pc_q + PC_INC;
   assign br_tgt   = branch_address & ~32'h3;
   // A pending redirect has already been latched; ignore new branches.
   assign accept    = is_branch && valid_id_q && !stall_IF && !redir_pend_q;
   assign redir_go  = redir_pend_q || accept;
   assign redir_tgt = redir_pend_q ? redir_pc_q : br_tgt;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      redir_pc_d    = redir_pc_q;
      redir_pend_d  = redir_pend_q;
      pc_plus4_id_d = pc_plus4_id_q;
      inst_id_d     = inst_id_q;
      valid_id_d    = valid_id_q;
      skid_load     = 1'b0;
      skid_unload   = 1'b0;

      unique case (state_q)
         FETCH: begin
            if (fire) begin
               pc_d = redir_go ? redir_tgt : pc_plus4;
               if (redir_go) begin
                  redir_pend_d = 1'b0;
               end
               if (redir_go && !DelaySlot) begin
                  // Squashed word: bubble unless IF/ID is being held.
                  if (!stall_IF) begin
                     inst_id_d  = NOP;
                     valid_id_d = 1'b0;
                  end
               end else if (!stall_IF) begin
                  pc_plus4_id_d = pc_plus4;
                  inst_id_d     = imem_rdata;
                  valid_id_d    = 1'b1;
               end else begin
                  skid_load = 1'b1;
                  state_d   = HOLD;
               end
            end else begin
               if (accept) begin
                  redir_pc_d   = br_tgt;
                  redir_pend_d = 1'b1;
               end
               if (!stall_IF) begin
                  inst_id_d  = NOP;
                  valid_id_d = 1'b0;
               end
            end
         end
         HOLD: begin
            if (!stall_IF) begin
               state_d     = FETCH;
               skid_unload = 1'b1;
               // The buffered word is the in-flight fetch; the PC has
               // already advanced past it but not been requested yet,
               // so the target can be loaded directly.
               if (accept) begin
                  pc_d = br_tgt;
               end
               if (accept && !DelaySlot) begin
                  inst_id_d  = NOP;
                  valid_id_d = 1'b0;
               end else begin
                  pc_plus4_id_d = skid_pc_plus4;
                  inst_id_d     = skid_inst;
                  valid_id_d    = 1'b1;
               end
            end
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= FETCH;
         pc_q          <= RESET_PC;
         redir_pc_q    <= '0;
         redir_pend_q  <= 1'b0;
         pc_plus4_id_q <= '0;
         inst_id_q     <= NOP;
         valid_id_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         redir_pc_q    <= redir_pc_d;
         redir_pend_q  <= redir_pend_d;
         pc_plus4_id_q <= pc_plus4_id_d;
         inst_id_q     <= inst_id_d;
         valid_id_q    <= valid_id_d;
      end
   end

   fetch_skid_buffer u_skid (
      .clk        (clk),
      .rst        (rst),
      .load_i     (skid_load),
      .unload_i   (skid_unload),
      .pc_plus4_i (pc_plus4),
      .inst_i     (imem_rdata),
      .pc_plus4_o (skid_pc_plus4),
      .inst_o     (skid_inst)
   );

   assign pc_plus4_ID = pc_plus4_id_q;
   assign inst_ID     = inst_id_q;
   assign valid_ID    = valid_id_q;

endmodule
